// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths, FSM encoding and constants for the fetch stage.
package instruction_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic {FETCH, DRAIN} state_e;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if_id.sv
// if_id_pipeline_register: IF/ID latch with flush-to-NOP, load and hold.
module if_id_pipeline_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);
  logic [XLEN-1:0] pc_q, pc_plus4_q, instr_q;
  logic            valid_q;
  // Flush leaves the PC fields untouched; only valid/instr mark the bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + 32'd4;
      instr_q    <= instr_i;
      valid_q    <= 1'b1;
    end
  end
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32I fetch stage owning the PC, imem handshake and IF/ID register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            branch_jump_mux_signal,
  input  logic [XLEN-1:0] Branch_jump_PC_OUT,
  input  logic            hazard_stall,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic [XLEN-1:0] imem_readdata,
  input  logic            imem_busywait,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_PC_plus4,
  output logic [XLEN-1:0] IF_ID_instr,
  output logic            IF_ID_valid
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, target;
  logic            read_q, load, flush;
  assign target = word_align(Branch_jump_PC_OUT);
  // pc_q is frozen while draining, so the abandoned access keeps its address.
  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    state_d   = state_q;
    load      = 1'b0;
    flush     = 1'b0;
    if (!read_q) begin
    end else if (state_q == DRAIN) begin
      flush     = 1'b1;
      pend_pc_d = branch_jump_mux_signal ? target : pend_pc_q;
      if (!imem_busywait) begin
        pc_d    = pend_pc_d;
        state_d = FETCH;
      end
    end else if (branch_jump_mux_signal) begin
      flush     = 1'b1;
      pc_d      = imem_busywait ? pc_q : target;
      pend_pc_d = imem_busywait ? target : pend_pc_q;
      state_d   = imem_busywait ? DRAIN : FETCH;
    end else if (hazard_stall) begin
    end else if (imem_busywait) begin
      flush = 1'b1;
    end else begin
      load = 1'b1;
      pc_d = pc_q + 32'd4;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      read_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      read_q    <= 1'b1;
    end
  end
  assign imem_read    = read_q;
  assign imem_address = pc_q;
  if_id_pipeline_register u_if_id (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (load),
    .flush_i    (flush),
    .pc_i       (pc_q),
    .instr_i    (imem_readdata),
    .pc_o       (IF_ID_PC),
    .pc_plus4_o (IF_ID_PC_plus4),
    .instr_o    (IF_ID_instr),
    .valid_o    (IF_ID_valid)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random fetch scenarios against a behavioural model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;
  logic        CLK = 1'b0, RESET = 1'b1, redirect = 1'b0, stall = 1'b0, busy = 1'b0;
  logic [31:0] target = '0;
  logic        imem_read, IF_ID_valid;
  logic [31:0] imem_address, imem_readdata, IF_ID_PC, IF_ID_PC_plus4, IF_ID_instr;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_if_pc, m_if_p4, m_if_instr;
  logic        m_valid, m_read;
  logic [31:0] pend[$];

  instruction_fetch_unit dut (
    .CLK(CLK), .RESET(RESET),
    .branch_jump_mux_signal(redirect), .Branch_jump_PC_OUT(target),
    .hazard_stall(stall),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_readdata(imem_readdata), .imem_busywait(busy),
    .IF_ID_PC(IF_ID_PC), .IF_ID_PC_plus4(IF_ID_PC_plus4),
    .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction
  assign imem_readdata = mem_word(imem_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_read", {31'b0, imem_read}, {31'b0, m_read});
    chk("imem_address", imem_address, m_pc);
    chk("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
    chk("IF_ID_instr", IF_ID_instr, m_if_instr);
    if (m_valid || !m_read) begin
      chk("IF_ID_PC", IF_ID_PC, m_if_pc);
      chk("IF_ID_PC_plus4", IF_ID_PC_plus4, m_if_p4);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_if_pc = 0; m_if_p4 = 0; m_if_instr = NOP; m_valid = 0; m_read = 0;
    pend.delete();
  endtask

  // One clock edge of fetch behaviour; a non-empty pend queue means an abandoned access is still in flight.
  task automatic model_update(input bit rd, input logic [31:0] t, input bit st, input bit bw);
    logic [31:0] ta;
    ta = {t[31:2], 2'b00};
    if (!m_read) m_read = 1;
    else if (pend.size() != 0) begin
      if (rd) begin pend.delete(); pend.push_back(ta); end
      m_valid = 0; m_if_instr = NOP;
      if (!bw) begin m_pc = pend.pop_front(); end
    end else if (rd) begin
      m_valid = 0; m_if_instr = NOP;
      if (bw) pend.push_back(ta); else m_pc = ta;
    end else if (st) begin
    end else if (bw) begin
      m_valid = 0; m_if_instr = NOP;
    end else begin
      m_if_pc = m_pc; m_if_p4 = m_pc + 4; m_if_instr = mem_word(m_pc); m_valid = 1;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic step(input bit rd, input logic [31:0] t, input bit st, input bit bw);
    @(negedge CLK);
    check_all();
    redirect = rd; target = t; stall = st; busy = bw;
    model_update(rd, t, st, bw);
  endtask

  task automatic do_reset();
    redirect = 0; stall = 0; busy = 0; target = 0;
    RESET = 1;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    check_all();
    RESET = 0;
    model_update(0, 0, 0, 0);
  endtask

  initial begin
    @(posedge CLK);
    #1;
    do_reset();
    repeat (5) step(0, 0, 0, 0);
    step(1, 32'h10, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);
    step(1, 32'h20, 0, 0);
    step(1, 32'h100, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 32'h30, 0, 0);
    step(0, 0, 0, 1);
    step(1, 32'h200, 0, 1);
    repeat (2) step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    step(1, 32'h40, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    step(1, 32'h80, 1, 0);
    step(0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0);
    step(1, 32'hFFFF_FFFE, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 32'h50, 0, 0);
    step(1, 32'h60, 0, 1);
    step(1, 32'h70, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    step(1, 32'h90, 0, 0);
    step(1, 32'h300, 0, 1);
    step(0, 0, 0, 1);
    @(posedge CLK);
    #2;
    do_reset();
    repeat (4) step(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(posedge CLK);
        #2;
        do_reset();
      end
      step($urandom_range(0, 6) == 0, $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end
    step(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
